// File: rtl/snake_body_store_pkg.sv
// Shared playfield constants, direction codes and the segment record used by
// the snake body store and the renderer.
package snake_body_store_pkg;
  localparam int GAME_WIDTH  = 20;
  localparam int GAME_HEIGHT = 15;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef struct packed {
    logic [4:0] x;
    logic [3:0] y;
    logic [1:0] dir;
  } segment_t;

  localparam int SEG_W = $bits(segment_t);
endpackage

// File: rtl/snake_body_store_mem.sv
// snake_ring_mem: 1W/1R register array with a registered, enabled read port.
module snake_ring_mem #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 11
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)  r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/snake_body_store.sv
// Ring-buffer store of snake segments: commits collision-checked moves and
// streams the body head->tail to the renderer once per video line.
module snake_body_store
  import snake_body_store_pkg::*;
#(
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 4,
  parameter int INIT_Y   = 7
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_line_start,
  input  logic       i_move_valid,
  output logic       o_move_ready,
  input  logic [4:0] i_move_x,
  input  logic [3:0] i_move_y,
  input  logic [1:0] i_move_dir,
  input  logic       i_move_grow,
  output logic       o_move_done,
  output logic       o_move_hit,
  output logic [4:0] o_snake_x,
  output logic [3:0] o_snake_y,
  output logic [1:0] o_snake_dir,
  output logic       o_snake_first,
  output logic       o_snake_last,
  output logic       o_snake_valid,
  output logic [5:0] o_length,
  output logic       o_full
);
  localparam int AW = $clog2(MAX_LEN);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_SCAN, S_CHECK, S_COMMIT} state_t;

  state_t        r_state;
  logic [AW-1:0] r_head_ptr;
  logic [5:0]    r_length, r_k;
  logic          r_pending, r_hit, r_cmp_vld, r_grow;
  segment_t      r_req;
  logic          r_move_done, r_move_hit, r_snake_valid, r_snake_first, r_snake_last;

  logic          w_we, w_re, w_last_k, w_match, w_hit_final;
  logic [AW-1:0] w_waddr, w_raddr;
  segment_t      w_wdata, w_rdata;

  assign w_last_k = (r_k == r_length - 6'd1);
  assign w_raddr  = r_head_ptr - r_k[AW-1:0];
  assign w_re     = (r_state == S_SCAN) || (r_state == S_CHECK);
  // Read data lags the address by one clk, so the last entry is compared in COMMIT.
  assign w_match     = r_cmp_vld && (w_rdata.x == r_req.x) && (w_rdata.y == r_req.y);
  assign w_hit_final = r_hit | w_match;

  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (i_rst_n && r_state == S_INIT) begin
      w_we    = 1'b1;
      w_waddr = r_k[AW-1:0];
      w_wdata = segment_t'{x: 5'(INIT_X - INIT_LEN + 1 + int'(r_k)), y: 4'(INIT_Y), dir: DIR_RIGHT};
    end else if (i_rst_n && r_state == S_COMMIT && !w_hit_final) begin
      w_we    = 1'b1;
      w_waddr = r_head_ptr + AW'(1);
      w_wdata = r_req;
    end
  end

  snake_ring_mem #(.DEPTH(MAX_LEN), .AW(AW), .DW(SEG_W)) u_mem (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= S_INIT;
      r_head_ptr    <= '0;
      r_length      <= '0;
      r_k           <= '0;
      r_pending     <= 1'b0;
      r_hit         <= 1'b0;
      r_cmp_vld     <= 1'b0;
      r_grow        <= 1'b0;
      r_req         <= '0;
      r_move_done   <= 1'b0;
      r_move_hit    <= 1'b0;
      r_snake_valid <= 1'b0;
      r_snake_first <= 1'b0;
      r_snake_last  <= 1'b0;
    end else begin
      r_move_done   <= 1'b0;
      r_move_hit    <= 1'b0;
      r_snake_valid <= 1'b0;
      r_snake_first <= 1'b0;
      r_snake_last  <= 1'b0;
      r_cmp_vld     <= 1'b0;
      case (r_state)
        S_INIT: begin
          if (r_k == 6'(INIT_LEN - 1)) begin
            r_length   <= 6'(INIT_LEN);
            r_head_ptr <= AW'(INIT_LEN - 1);
            r_k        <= '0;
            r_state    <= S_IDLE;
          end else begin
            r_k <= r_k + 6'd1;
          end
        end
        S_IDLE: begin
          r_k <= '0;
          if (i_line_start) begin
            r_state <= S_SCAN;
          end else if (i_move_valid) begin
            r_req   <= segment_t'{x: i_move_x, y: i_move_y, dir: i_move_dir};
            r_grow  <= i_move_grow;
            r_hit   <= 1'b0;
            r_state <= S_CHECK;
          end
        end
        S_SCAN: begin
          r_snake_valid <= 1'b1;
          r_snake_first <= (r_k == 6'd0);
          r_snake_last  <= w_last_k;
          if (w_last_k) r_state <= S_IDLE;
          else          r_k     <= r_k + 6'd1;
        end
        S_CHECK: begin
          if (i_line_start) r_pending <= 1'b1;
          r_hit     <= w_hit_final;
          // Without grow the tail moves away this step, so it cannot be hit.
          r_cmp_vld <= r_grow || !w_last_k;
          if (w_last_k) r_state <= S_COMMIT;
          else          r_k     <= r_k + 6'd1;
        end
        S_COMMIT: begin
          r_move_done <= 1'b1;
          r_move_hit  <= w_hit_final;
          if (!w_hit_final) begin
            r_head_ptr <= r_head_ptr + AW'(1);
            if (r_grow && r_length != 6'(MAX_LEN)) r_length <= r_length + 6'd1;
          end
          r_pending <= 1'b0;
          r_k       <= '0;
          r_state   <= (r_pending || i_line_start) ? S_SCAN : S_IDLE;
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign o_move_ready  = i_rst_n && (r_state == S_IDLE) && !i_line_start;
  assign o_move_done   = r_move_done;
  assign o_move_hit    = r_move_hit;
  assign o_snake_x     = w_rdata.x;
  assign o_snake_y     = w_rdata.y;
  assign o_snake_dir   = w_rdata.dir;
  assign o_snake_first = r_snake_first;
  assign o_snake_last  = r_snake_last;
  assign o_snake_valid = r_snake_valid;
  assign o_length      = r_length;
  assign o_full        = (r_length == 6'(MAX_LEN));
endmodule

// File: tb/tb_snake_body_store.sv
// Directed bench for snake_body_store: init, scans, moves, collisions,
// deferred scans, saturation at full length and reset during a scan.
module tb_snake_body_store;
  logic       clk, rst_n, line_start, move_valid, move_grow;
  logic [4:0] move_x;
  logic [3:0] move_y;
  logic [1:0] move_dir;
  logic       move_ready, move_done, move_hit;
  logic [4:0] snake_x;
  logic [3:0] snake_y;
  logic [1:0] snake_dir;
  logic       snake_first, snake_last, snake_valid, full;
  logic [5:0] length;

  int checks = 0, failures = 0;
  int sx[64], sy[64], sd[64], sf[64], sl[64];

  snake_body_store dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_line_start(line_start),
    .i_move_valid(move_valid), .o_move_ready(move_ready),
    .i_move_x(move_x), .i_move_y(move_y), .i_move_dir(move_dir), .i_move_grow(move_grow),
    .o_move_done(move_done), .o_move_hit(move_hit),
    .o_snake_x(snake_x), .o_snake_y(snake_y), .o_snake_dir(snake_dir),
    .o_snake_first(snake_first), .o_snake_last(snake_last), .o_snake_valid(snake_valid),
    .o_length(length), .o_full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Gather one scan burst; first_c is the tick index of the first valid segment.
  task automatic collect(output int n, output int first_c);
    n = 0;
    first_c = -1;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (snake_valid) begin
        if (first_c < 0) first_c = c;
        if (n < 64) begin
          sx[n] = snake_x; sy[n] = snake_y; sd[n] = snake_dir;
          sf[n] = snake_first; sl[n] = snake_last;
        end
        n++;
        if (snake_last) break;
      end else if (c > 40) break;
    end
  endtask

  task automatic scan(input string tag, input int exp_len);
    int n, fc;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    collect(n, fc);
    chk({tag, "_len"}, n, exp_len);
    chk({tag, "_lat"}, fc, 0);
    chk({tag, "_first"}, sf[0], 1);
    if (n > 0 && n <= 64) chk({tag, "_last"}, sl[n-1], 1);
  endtask

  task automatic seg(input string tag, input int k, input int x, input int y);
    chk({tag, "_x"}, sx[k], x);
    chk({tag, "_y"}, sy[k], y);
  endtask

  // Waits for move_done, dropping move_valid once accepted; lat counts clks from acceptance.
  task automatic wait_done(output int hit, output int lat, output int nvalid);
    logic rdy;
    hit = -1; lat = -1; nvalid = 0;
    for (int c = 0; c < 200; c++) begin
      rdy = move_ready && move_valid;
      tick();
      if (rdy) begin move_valid = 1'b0; lat = 0; end
      else if (lat >= 0) lat++;
      if (snake_valid) nvalid++;
      if (move_done) begin hit = move_hit; return; end
    end
    chk("move_done_timeout", 0, 1);
  endtask

  task automatic move(input int x, input int y, input int d, input int g, output int hit, output int lat);
    int nv;
    move_x = 5'(x); move_y = 4'(y); move_dir = 2'(d); move_grow = g[0];
    move_valid = 1'b1;
    wait_done(hit, lat, nv);
  endtask

  int hit, lat, nv, n, fc, hits;

  initial begin
    rst_n = 1'b0; line_start = 1'b0; move_valid = 1'b0; move_grow = 1'b0;
    move_x = '0; move_y = '0; move_dir = '0;
    tick(); tick(); tick();
    chk("rst_ready", move_ready, 0);
    chk("rst_length", length, 0);
    chk("rst_valid", snake_valid, 0);
    chk("rst_done", move_done, 0);
    chk("rst_full", full, 0);

    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("init_length", length, 3);
    chk("init_ready", move_ready, 1);

    scan("scan0", 3);
    seg("s0a", 0, 4, 7); seg("s0b", 1, 3, 7); seg("s0c", 2, 2, 7);
    chk("s0_dir", sd[0], 1);

    move(5, 7, 1, 0, hit, lat);
    chk("mv1_hit", hit, 0); chk("mv1_lat", lat, 4);
    scan("scan1", 3);
    seg("s1a", 0, 5, 7); seg("s1b", 1, 4, 7); seg("s1c", 2, 3, 7);
    chk("mv1_length", length, 3);

    move(5, 8, 2, 1, hit, lat);
    chk("grow_hit", hit, 0); chk("grow_length", length, 4); chk("grow_full", full, 0);
    scan("scan2", 4);
    seg("s2a", 0, 5, 8); seg("s2d", 3, 3, 7);

    // Tail vacates without grow: stepping onto it is legal.
    move(3, 7, 3, 0, hit, lat);
    chk("tail_hit", hit, 0); chk("tail_lat", lat, 5);
    // Body now (3,7)(5,8)(5,7)(4,7).
    move(5, 7, 0, 0, hit, lat);
    chk("mid_hit", hit, 1);
    move(4, 7, 0, 1, hit, lat);
    chk("tailgrow_hit", hit, 1); chk("hit_length", length, 4);
    scan("scan3", 4);
    seg("s3a", 0, 3, 7); seg("s3b", 1, 5, 8); seg("s3c", 2, 5, 7); seg("s3d", 3, 4, 7);

    // line_start during CHECK defers the scan until after COMMIT.
    move_x = 5'd2; move_y = 4'd7; move_dir = 2'd3; move_grow = 1'b0; move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    wait_done(hit, lat, nv);
    chk("pend_hit", hit, 0); chk("pend_novalid", nv, 0);
    collect(n, fc);
    chk("pend_len", n, 4); chk("pend_lat", fc, 0);
    seg("s4a", 0, 2, 7); seg("s4d", 3, 5, 7);

    // line_start and move_valid together: scan wins, move follows.
    move_x = 5'd1; move_y = 4'd7; move_dir = 2'd3; move_grow = 1'b0; move_valid = 1'b1;
    line_start = 1'b1;
    #1;
    chk("prio_ready", move_ready, 0);
    tick();
    line_start = 1'b0;
    collect(n, fc);
    chk("prio_len", n, 4);
    seg("s5a", 0, 2, 7);
    wait_done(hit, lat, nv);
    chk("prio_hit", hit, 0); chk("prio_lat", lat, 5);
    scan("scan6", 4);
    seg("s6a", 0, 1, 7); seg("s6d", 3, 5, 8);

    // Grow 40 times on distinct cells: saturates at 32, head pointer wraps.
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      move((i % 20) + 1, 10 + i / 20, 1, 1, hit, lat);
      if (hit != 0) hits++;
    end
    chk("sat_hits", hits, 0);
    chk("sat_length", length, 32);
    chk("sat_full", full, 1);
    scan("scan7", 32);
    seg("s7head", 0, 20, 11);
    seg("s7tail", 31, 9, 10);
    seg("s7mid", 12, 8, 11);

    // Reset mid-scan.
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    tick(); tick();
    chk("mid_scan_valid", snake_valid, 1);
    rst_n = 1'b0;
    tick();
    chk("rst2_valid", snake_valid, 0);
    chk("rst2_length", length, 0);
    chk("rst2_ready", move_ready, 0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("init2_length", length, 3);
    scan("scan8", 3);
    seg("s8a", 0, 4, 7); seg("s8c", 2, 2, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
